vst_serializer: RTL
===================

# vst_serializer

Downstream of the vector ALU: captures one 256-bit vector result (16 lanes × 16-bit half-precision) and writes it lane by lane into 16-bit-wide data memory at 16 consecutive addresses. This is the VST execution path. It holds the vector locally, so the ALU result register may change on the cycle after `start`. A ready/valid-style write handshake lets the block tolerate memory wait states.

## Interface
- `LANES`, 16, number of lanes per vector
- `LANE_W`, 16, bits per lane; vector width = `LANES*LANE_W` (256)
- `ADDR_W`, 16, memory address width
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request store of `vec` at `base_addr`; sampled only in IDLE
- `vec`  in  256  vector to store; lane i = `vec[16*i+15 : 16*i]`
- `base_addr`  in  16  address of lane 0
- `busy`  out  1  high in WRITE and DONE
- `done`  out  1  one-cycle pulse when the last lane has been accepted
- `mem_we`  out  1  write request, valid
- `mem_addr`  out  16  write address
- `mem_wdata`  out  16  write data
- `mem_ready`  in  1  memory accepts the current write at this rising edge when `mem_we`=1

## Operation
- States: IDLE, WRITE, DONE.
- IDLE:
  - `start`=1 captures `vec` into a 256-bit holding register, captures `base_addr`, clears the lane counter (4 bits), and goes to WRITE.
  - `start`=0 stays in IDLE.
- WRITE:
  - `mem_we`=1, `mem_addr`=`base_addr`+lane (mod 2^16, wrap 0xFFFF→0x0000), `mem_wdata`=held lane[counter].
  - An edge with `mem_ready`=1 counts as accepted:
    - lane < 15: increment the counter.
    - lane = 15: go to DONE.
  - `mem_ready`=0: hold addr/data/we stable; no advance. There is no timeout.
- DONE: `done`=1, `mem_we`=0, unconditional return to IDLE next edge.
- `start` in WRITE or DONE is ignored and not queued; the held vector is unaffected by `vec` changes after capture.
- `mem_ready` while `mem_we`=0 is ignored.
- Memory always receives lanes in order 0..15, each exactly once.
- `mem_addr`/`mem_wdata` are 0 when `mem_we`=0.
- All outputs come directly from registers or a state decode; there is no combinational path from `mem_ready` or `start` to any output.

## Timing
- Reset values:
  - state IDLE; `busy`=0, `done`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Holding register, base and counter cleared to 0.
- Reset asserted mid-store takes effect immediately (asynchronous):
  - `mem_we` drops without waiting for a clock; the remaining lanes are abandoned; no `done`.
  - After deassertion the block is in IDLE and needs a new `start`.
- Latency with `mem_ready` tied high:
  - `start` sampled at edge 0.
  - Lane i is presented during cycle i+1 and accepted at edge i+1.
  - `done` is high during cycle 17.
  - `busy` is low again in cycle 18.
  - Total: 18 cycles start-to-idle.
- Each low `mem_ready` cycle in WRITE adds exactly one cycle.
- Back-to-back stores: `start` held high in the IDLE cycle after DONE is accepted; the minimum issue interval is 18 cycles.

## Test plan
- Reset then idle:
  - Stimulus: assert `rst` with `clk` stopped.
  - Required: all outputs 0 immediately; after release, `busy`=0 and `mem_we`=0 for 5 cycles with `start`=0.
- Basic store:
  - Stimulus: lane i = 16'h3C00+i, `base_addr`=0x0100, `mem_ready`=1.
  - Required: writes (0x0100,0x3C00) … (0x010F,0x3C0F) on consecutive cycles 1–16; `done` only in cycle 17.
- Wait states:
  - Stimulus: same vector, `mem_ready` low on lanes 0, 7 (2 cycles) and 15.
  - Required: addr/data held stable during stalls; 16 writes, each once; `done` in cycle 21.
- Address wrap plus ignored start:
  - Stimulus: `base_addr`=0xFFF8; pulse `start` with a different `vec` during WRITE.
  - Required: addresses run 0xFFF8..0xFFFF then 0x0000..0x0007; data is from the first vector only; no second store occurs.
- Reset mid-store:
  - Stimulus: assert `rst` asynchronously after lane 5 is accepted.
  - Required: `mem_we`=0 at once; no `done`; a subsequent `start` with `base_addr`=0x0200 writes lane 0 to 0x0200.
- Back-to-back:
  - Stimulus: `start` held high continuously, `mem_ready`=1.
  - Required: stores begin at edges 0, 18, 36; `done` in cycles 17, 35.

Source files
------------

// File: rtl/vst_serializer.sv
// Vector store serializer: captures one LANES x LANE_W vector and writes it
// lane by lane to consecutive memory addresses with a ready/valid handshake.
module vst_serializer #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [LANES*LANE_W-1:0]   vec,
    input  logic [ADDR_W-1:0]         base_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LANE_W-1:0]         mem_wdata,
    input  logic                      mem_ready
);

    localparam int CNT_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [LANES*LANE_W-1:0]   vec_q, vec_d;
    logic [ADDR_W-1:0]         base_q, base_d;
    logic [CNT_W-1:0]          lane_q, lane_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            base_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            base_q  <= base_d;
            lane_q  <= lane_d;
        end
    end

    // Outputs decode only registered state, so mem_ready/start never reach them.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        base_d    = base_q;
        lane_d    = lane_q;
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    vec_d   = vec;
                    base_d  = base_addr;
                    lane_d  = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + ADDR_W'(lane_q);
                mem_wdata = vec_q[lane_q*LANE_W +: LANE_W];
                if (mem_ready) begin
                    if (lane_q == LAST_LANE) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
